// File: rtl/async_fifo_reader.sv
// Read-side drainer for the CDC FIFO: issues gets, absorbs the 1-cycle read latency
// in a 2-entry skid buffer and presents a valid/ready stream with a delivered-word count.
module async_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  output logic                  o_get_en,
  input  logic [DATA_WIDTH-1:0] i_get_cmd,
  input  logic                  i_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  o_xfer_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;

  occ_e                  state, state_nxt;
  logic                  inflight;
  logic                  pop, push, room;
  logic [DATA_WIDTH-1:0] slot0, slot1;

  assign pop     = m_valid & m_ready;
  assign push    = inflight;
  assign m_valid = (state != EMPTY);
  assign m_data  = slot0;

  // room: occ + inflight < 2, i.e. a new get still has a reserved slot
  always_comb begin
    state_nxt = state;
    room      = 1'b0;
    case (state)
      EMPTY: begin
        room = 1'b1;
        if (push) state_nxt = ONE;
      end
      ONE: begin
        room = ~inflight;
        if (push & ~pop)      state_nxt = TWO;
        else if (~push & pop) state_nxt = EMPTY;
      end
      TWO: begin
        room = 1'b0;
        if (~push & pop) state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
    o_get_en = ~i_empty & ~i_clear & ~reset & (room | pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      inflight   <= 1'b0;
      slot0      <= '0;
      slot1      <= '0;
      o_xfer_cnt <= '0;
    end else if (i_clear) begin
      state      <= EMPTY;
      inflight   <= 1'b0;
      slot0      <= '0;
      slot1      <= '0;
      o_xfer_cnt <= '0;
    end else begin
      state      <= state_nxt;
      inflight   <= o_get_en;
      o_xfer_cnt <= o_xfer_cnt + {{(CNT_WIDTH-1){1'b0}}, pop};
      if (pop && state == TWO) slot0 <= slot1;
      // landing slot is occ - pop
      if (push) begin
        if ((state == ONE && !pop) || state == TWO) slot1 <= i_get_cmd;
        else                                        slot0 <= i_get_cmd;
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_reader.sv
// Randomized + directed bench: a queue-based FIFO and scoreboard model check
// ordering, latency, back-pressure, flush, counter wrap and get/empty safety.
module tb_async_fifo_reader;

  logic        clk = 1'b0, reset = 1'b0, i_clear = 1'b0, m_ready = 1'b0;
  logic [7:0]  i_get_cmd = 8'd0;
  logic        i_empty;
  logic        o_get_en, m_valid;
  logic [7:0]  m_data;
  logic [15:0] o_xfer_cnt;
  logic        get_en4, m_valid4;
  logic [7:0]  m_data4;
  logic [3:0]  cnt4;

  logic [7:0]  mem [256];
  int          wr_ptr = 0, rd_ptr = 0;
  logic [7:0]  exp_q [$];
  int          cnt_m = 0, drop_n = 0;
  int          n_chk = 0, n_err = 0;
  logic        hold_pending = 1'b0;
  logic [7:0]  prev_data = 8'd0;

  async_fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .i_clear(i_clear), .o_get_en(o_get_en),
    .i_get_cmd(i_get_cmd), .i_empty(i_empty), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .o_xfer_cnt(o_xfer_cnt));

  async_fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .i_clear(i_clear), .o_get_en(get_en4),
    .i_get_cmd(i_get_cmd), .i_empty(i_empty), .m_valid(m_valid4),
    .m_data(m_data4), .m_ready(m_ready), .o_xfer_cnt(cnt4));

  always #5 clk = ~clk;

  assign i_empty = (wr_ptr == rd_ptr);

  // FIFO with 1-cycle read latency, plus scoreboard of words removed but not yet delivered
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      cnt_m = 0;
    end else if (i_clear) begin
      drop_n = exp_q.size();
      exp_q.delete();
      cnt_m = 0;
    end else begin
      if (m_valid && m_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        cnt_m = cnt_m + 1;
      end
      if (o_get_en) begin
        i_get_cmd <= mem[rd_ptr % 256];
        exp_q.push_back(mem[rd_ptr % 256]);
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 256] = d;
    wr_ptr++;
  endtask

  task automatic monitor();
    chk("get_when_empty", {31'd0, o_get_en & i_empty}, 32'd0);
    chk("get_when_clear", {31'd0, o_get_en & i_clear}, 32'd0);
    chk("cnt", {16'd0, o_xfer_cnt}, cnt_m & 32'hFFFF);
    chk("cnt4", {28'd0, cnt4}, cnt_m & 32'hF);
    chk("reserve_cap", {31'd0, exp_q.size() <= 2}, 32'd1);
    if (m_valid) begin
      if (exp_q.size() == 0) chk("order_noword", 32'd0, 32'd1);
      else                   chk("order", {24'd0, m_data}, {24'd0, exp_q[0]});
    end
    if (hold_pending && !reset) begin
      chk("hold_valid", {31'd0, m_valid}, 32'd1);
      chk("hold_data", {24'd0, m_data}, {24'd0, prev_data});
    end
    hold_pending = m_valid & ~m_ready & ~i_clear & ~reset;
    prev_data    = m_data;
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done = 0;
    m_ready = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      sample();
      if (i_empty && exp_q.size() == 0 && !m_valid) done = 1;
      tick();
    end
    chk("drain_done", {31'd0, done}, 32'd1);
  endtask

  task automatic clear_pulse();
    i_clear = 1'b1;
    sample();
    tick();
    i_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // T1: async reset with a word waiting
    push(8'hA5);
    #2 reset = 1'b1;
    #1;
    chk("t1_get_en", {31'd0, o_get_en}, 32'd0);
    chk("t1_valid", {31'd0, m_valid}, 32'd0);
    chk("t1_data", {24'd0, m_data}, 32'd0);
    chk("t1_cnt", {16'd0, o_xfer_cnt}, 32'd0);
    chk("t1_cnt4", {28'd0, cnt4}, 32'd0);
    tick();
    tick();
    m_ready = 1'b1;
    reset   = 1'b0;

    // T2: single-word latency
    sample(); chk("t2_get_c0", {31'd0, o_get_en}, 32'd1); tick();
    sample(); chk("t2_valid_c1", {31'd0, m_valid}, 32'd0); tick();
    sample(); chk("t2_valid_c2", {31'd0, m_valid}, 32'd1);
    chk("t2_data_c2", {24'd0, m_data}, 32'hA5); tick();
    sample(); chk("t2_cnt", {16'd0, o_xfer_cnt}, 32'd1);
    chk("t2_valid_c3", {31'd0, m_valid}, 32'd0); tick();

    clear_pulse();
    sample(); chk("clr_cnt", {16'd0, o_xfer_cnt}, 32'd0); tick();

    // T3: back-to-back streaming
    for (int i = 0; i < 16; i++) push(8'(i));
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      sample();
      if (m_valid) seen = 1; else tick();
    end
    chk("t3_start", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin tick(); sample(); end
      chk("t3_valid", {31'd0, m_valid}, 32'd1);
      chk("t3_data", {24'd0, m_data}, i);
    end
    tick();
    sample();
    chk("t3_cnt", {16'd0, o_xfer_cnt}, 32'd16);
    chk("t3_idle", {31'd0, m_valid}, 32'd0);
    tick();

    // T4: back-pressure mid-stream
    for (int i = 16; i < 36; i++) push(8'(i));
    for (int k = 0; k < 6; k++) begin sample(); tick(); end
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("t4_stall_get", {31'd0, o_get_en}, 32'd0);
      chk("t4_stall_valid", {31'd0, m_valid}, 32'd1);
      tick();
    end
    m_ready = 1'b1;
    sample(); chk("t4_resume_get", {31'd0, o_get_en}, 32'd1); tick();
    drain();
    sample(); chk("t4_cnt", {16'd0, o_xfer_cnt}, 32'd36); tick();

    // T5: flush with the reservation full
    clear_pulse();
    for (int i = 0; i < 10; i++) push(8'(100 + i));
    for (int k = 0; k < 4; k++) begin sample(); tick(); end
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin sample(); tick(); end
    clear_pulse();
    sample();
    chk("t5_valid", {31'd0, m_valid}, 32'd0);
    chk("t5_cnt", {16'd0, o_xfer_cnt}, 32'd0);
    chk("t5_drop", drop_n, 32'd2);
    tick();
    m_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      sample();
      if (m_valid) seen = 1; else tick();
    end
    chk("t5_next", {24'd0, m_data}, 32'd104);
    tick();
    drain();
    sample(); chk("t5_cnt_end", {16'd0, o_xfer_cnt}, 32'd6); tick();

    // T6: 4-bit counter wrap
    clear_pulse();
    for (int i = 0; i < 17; i++) push(8'(200 + i));
    drain();
    sample();
    chk("t6_cnt4", {28'd0, cnt4}, 32'd1);
    chk("t6_cnt16", {16'd0, o_xfer_cnt}, 32'd17);
    tick();

    // randomized traffic with occasional flush and one mid-stream reset
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(2, 0) == 0 && (wr_ptr - rd_ptr) < 200) push(8'($urandom));
      m_ready = ($urandom_range(3, 0) != 0);
      i_clear = ($urandom_range(49, 0) == 0);
      if (k == 200) begin
        i_clear = 1'b0;
        reset   = 1'b1;
        #1;
        chk("rst_get_en", {31'd0, o_get_en}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_cnt", {16'd0, o_xfer_cnt}, 32'd0);
        hold_pending = 1'b0;
        tick();
        reset = 1'b0;
      end
      sample();
      tick();
    end
    i_clear = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
